// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs RATIO FIFO words into one wide valid/ready beat.
// Partial packs are closed by flush or idle timeout and flagged with m_keep/m_last.
module fifo_rd_packer #(
   parameter  int unsigned DSIZE = 8,
   parameter  int unsigned RATIO = 4,
   parameter  int unsigned TMO   = 16,
   localparam int unsigned CW    = $clog2(RATIO + 1),
   localparam int unsigned TW    = (TMO > 0) ? $clog2(TMO + 1) : 1,
   localparam int unsigned BW    = DSIZE * RATIO
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [DSIZE-1:0] fifo_rdata,
   input  logic             fifo_rempty,
   output logic             fifo_rinc,
   input  logic             flush,
   output logic [BW-1:0]    m_data,
   output logic [RATIO-1:0] m_keep,
   output logic             m_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CW-1:0]    pack_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_FULLW = 2'd2
   } state_e;

   logic [BW-1:0]    pack_q,    pack_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [TW-1:0]    ctr_q,     ctr_d;
   logic [BW-1:0]    m_data_q,  m_data_d;
   logic [RATIO-1:0] m_keep_q,  m_keep_d;
   logic             m_last_q,  m_last_d;
   logic             m_valid_q, m_valid_d;

   state_e           state_c;
   logic             out_free_c;
   logic             tmo_hit_c;
   logic             close_c;
   logic             xfer_c;
   logic             pop_c;
   logic [RATIO-1:0] keep_c;

   // Pack occupancy and close/transfer/pop decisions
   always_comb begin
      state_c = ST_IDLE;
      if (cnt_q == CW'(RATIO)) begin
         state_c = ST_FULLW;
      end else if (cnt_q != '0) begin
         state_c = ST_FILL;
      end
      out_free_c = !m_valid_q || m_ready;
      tmo_hit_c  = (TMO != 0) && (ctr_q == TW'(TMO));
      close_c    = (state_c == ST_FULLW) ||
                   ((state_c != ST_IDLE) && (flush || tmo_hit_c));
      xfer_c     = close_c && out_free_c;
      pop_c      = rrst_n && !fifo_rempty && ((state_c != ST_FULLW) || xfer_c);
      for (int i = 0; i < RATIO; i++) begin
         keep_c[i] = (CW'(i) < cnt_q);
      end
   end

   // Next pack, timeout counter and output register contents
   always_comb begin
      pack_d    = pack_q;
      cnt_d     = cnt_q;
      ctr_d     = ctr_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
      m_valid_d = m_valid_q;

      if (xfer_c) begin
         m_valid_d = 1'b1;
         m_keep_d  = keep_c;
         m_last_d  = (state_c != ST_FULLW) || flush;
         for (int i = 0; i < RATIO; i++) begin
            m_data_d[i*DSIZE +: DSIZE] = keep_c[i] ? pack_q[i*DSIZE +: DSIZE] : '0;
         end
         pack_d = '0;
         cnt_d  = '0;
         // A word popped on the closing edge starts the next pack at lane 0
         if (pop_c) begin
            pack_d[DSIZE-1:0] = fifo_rdata;
            cnt_d             = CW'(1);
         end
      end else begin
         if (m_ready) begin
            m_valid_d = 1'b0;
         end
         if (pop_c) begin
            for (int i = 0; i < RATIO; i++) begin
               if (CW'(i) == cnt_q) begin
                  pack_d[i*DSIZE +: DSIZE] = fifo_rdata;
               end
            end
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (pop_c || xfer_c || (state_c == ST_IDLE)) begin
         ctr_d = '0;
      end else if (ctr_q != TW'(TMO)) begin
         ctr_d = ctr_q + TW'(1);
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         pack_q    <= '0;
         cnt_q     <= '0;
         ctr_q     <= '0;
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else begin
         pack_q    <= pack_d;
         cnt_q     <= cnt_d;
         ctr_q     <= ctr_d;
         m_data_q  <= m_data_d;
         m_keep_q  <= m_keep_d;
         m_last_q  <= m_last_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign fifo_rinc = pop_c;
   assign m_data    = m_data_q;
   assign m_keep    = m_keep_q;
   assign m_last    = m_last_q;
   assign m_valid   = m_valid_q;
   assign pack_cnt  = cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-modelled FIFO, byte-order scoreboard, directed and random traffic.
module tb_fifo_rd_packer;
   localparam int unsigned DSIZE = 8;
   localparam int unsigned RATIO = 4;
   localparam int unsigned TMO   = 16;
   localparam int unsigned CW    = $clog2(RATIO + 1);

   logic             clk;
   logic             rrst_n;
   logic [DSIZE-1:0] fifo_rdata;
   logic             fifo_rempty;
   logic             fifo_rinc;
   logic             flush;
   logic [31:0]      m_data;
   logic [3:0]       m_keep;
   logic             m_last;
   logic             m_valid;
   logic             m_ready;
   logic [CW-1:0]    pack_cnt;

   int          checks;
   int          errors;
   logic [7:0]  fq[$];
   logic [7:0]  exp_q[$];
   logic        rinc_s;

   fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO), .TMO(TMO)) dut (
      .rclk        (clk),
      .rrst_n      (rrst_n),
      .fifo_rdata  (fifo_rdata),
      .fifo_rempty (fifo_rempty),
      .fifo_rinc   (fifo_rinc),
      .flush       (flush),
      .m_data      (m_data),
      .m_keep      (m_keep),
      .m_last      (m_last),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .pack_cnt    (pack_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fifo_upd();
      fifo_rempty = (fq.size() == 0);
      fifo_rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
      fifo_upd();
   endtask

   // Called at posedge+1; returns at the next posedge+1 with the FIFO model updated
   task automatic tick();
      #2 rinc_s = fifo_rinc;
      @(posedge clk);
      #1;
      if (rinc_s && fq.size() != 0) void'(fq.pop_front());
      fifo_upd();
   endtask

   task automatic drain();
      int t;
      m_ready = 1'b1;
      flush   = 1'b1;
      t = 0;
      while ((fq.size() != 0 || pack_cnt != '0 || m_valid) && t < 200) begin
         tick();
         t++;
      end
      flush = 1'b0;
      check("drain_bound", 64'(t < 200), 64'd1);
      check("drain_exp_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: scores every accepted beat against the FIFO input order
   initial begin : monitor
      logic        hold;
      logic [31:0] hd;
      logic [3:0]  hk;
      logic        hl;
      logic [31:0] ed;
      logic [3:0]  mask;
      int          k;
      hold = 1'b0;
      hd = '0; hk = '0; hl = 1'b0;
      forever begin
         @(posedge clk);
         #4;
         if (!rrst_n) begin
            hold = 1'b0;
         end else begin
            if (fifo_rempty) check("rinc_while_empty", 64'(fifo_rinc), 64'd0);
            if (hold) check("hold_stable", 64'({m_valid, m_last, m_keep, m_data}),
                            64'({1'b1, hl, hk, hd}));
            if (m_valid && m_ready) begin
               k = 0;
               while (k < 4 && m_keep[k]) k++;
               mask = 4'((1 << k) - 1);
               check("beat_keep", 64'(m_keep), (k == 0) ? 64'h1 : 64'(mask));
               if (!m_last) check("beat_full_unless_last", 64'(k), 64'd4);
               check("beat_underrun", 64'(exp_q.size() >= k), 64'd1);
               ed = '0;
               for (int i = 0; i < k; i++) begin
                  if (exp_q.size() != 0) ed[i*8 +: 8] = exp_q.pop_front();
               end
               check("beat_data", 64'(m_data), 64'(ed));
            end
            hold = m_valid && !m_ready;
            hd = m_data;
            hk = m_keep;
            hl = m_last;
         end
      end
   end

   initial begin : driver
      int n;
      checks = 0;
      errors = 0;
      rrst_n  = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b0;
      fifo_upd();
      @(posedge clk);
      #1;
      check("reset_outputs", 64'({m_valid, m_last, m_keep, m_data, pack_cnt, fifo_rinc}), 64'd0);
      rrst_n = 1'b1;

      // Two full beats at full rate
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push(8'(i));
      n = 0;
      for (int t = 1; t <= 9; t++) begin
         tick();
         if (t <= 8 && rinc_s) n++;
         if (t == 5) check("t1_beat0", 64'({m_valid, m_last, m_keep, m_data}),
                           64'({1'b1, 1'b0, 4'hF, 32'h04030201}));
         if (t == 9) check("t1_beat1", 64'({m_valid, m_last, m_keep, m_data}),
                           64'({1'b1, 1'b0, 4'hF, 32'h08070605}));
      end
      check("t1_pops", 64'(n), 64'd8);
      drain();

      // Idle timeout closes a two-word pack
      push(8'hA1);
      push(8'hA2);
      for (int t = 1; t <= 19; t++) begin
         tick();
         if (t == 2)  check("t2_cnt", 64'(pack_cnt), 64'd2);
         if (t == 18) check("t2_no_early", 64'(m_valid), 64'd0);
         if (t == 19) check("t2_beat", 64'({m_valid, m_last, m_keep, m_data}),
                            64'({1'b1, 1'b1, 4'h3, 32'h0000A2A1}));
      end
      drain();

      // Backpressure: held beat, second pack waits in FULLW
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
      for (int t = 0; t < 15; t++) tick();
      check("t3_held", 64'({m_valid, m_keep, m_data}), 64'({1'b1, 4'hF, 32'h33323130}));
      for (int i = 0; i < 5; i++) push(8'(8'h34 + i));
      for (int t = 0; t < 4; t++) tick();
      tick();
      check("t3_stall_rinc", 64'(rinc_s), 64'd0);
      tick();
      check("t3_fullw", 64'({pack_cnt, 8'(fq.size())}), 64'({3'd4, 8'd1}));
      m_ready = 1'b1;
      tick();
      check("t3_second", 64'({m_valid, m_data, pack_cnt}), 64'({1'b1, 32'h37363534, 3'd1}));
      drain();

      // Flush with same-cycle pop, then flush with an empty pack
      for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
      for (int t = 0; t < 3; t++) tick();
      check("t4_cnt3", 64'(pack_cnt), 64'd3);
      push(8'h43);
      flush = 1'b1;
      tick();
      check("t4_partial", 64'({m_valid, m_last, m_keep, m_data}),
            64'({1'b1, 1'b1, 4'h7, 32'h00424140}));
      check("t4_newpack", 64'(pack_cnt), 64'd1);
      tick();
      check("t4_single", 64'({m_valid, m_last, m_keep, m_data}),
            64'({1'b1, 1'b1, 4'h1, 32'h00000043}));
      tick();
      check("t4_no_empty_beat", 64'({m_valid, pack_cnt}), 64'd0);
      flush = 1'b0;
      drain();

      // Asynchronous reset mid-pack
      m_ready = 1'b0;
      for (int i = 0; i < 7; i++) push(8'(8'h50 + i));
      for (int t = 0; t < 6; t++) tick();
      check("t5_pre", 64'({m_valid, pack_cnt}), 64'({1'b1, 3'd2}));
      rrst_n = 1'b0;
      #1;
      check("t5_reset_out", 64'({m_valid, m_last, m_keep, m_data, pack_cnt, fifo_rinc}), 64'd0);
      fq.delete();
      exp_q.delete();
      fifo_upd();
      @(posedge clk);
      #1;
      rrst_n  = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
      for (int t = 1; t <= 5; t++) begin
         tick();
         if (t == 5) check("t5_fresh", 64'({m_valid, m_keep, m_data}),
                           64'({1'b1, 4'hF, 32'h14131211}));
      end
      drain();

      // Random traffic with periodic quiet gaps to exercise the timeout
      for (int c = 0; c < 10000; c++) begin
         if ((c % 500) < 460 && $urandom_range(0, 99) < 45) push(8'($urandom));
         m_ready = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 99) < 3);
         tick();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
